// File: rtl/bus_memory.sv
// -----------------------------------------------------------------------------
// bus_memory
//   Word-organised, little-endian memory slave for the CPU request/response
//   bus. Depth and response latency are set by parameters. Byte, half and word
//   accesses are supported. Storage is an inferred RAM that reset never clears.
//
// Parameters
//   DATA_W       bus data width (only 32 is supported)
//   ADDR_W       byte-address width
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 4)
//   LATENCY      cycles from request sample to response (1..255)
//   INIT_FILE    name of the hex image the memory-init flow loads into 'mem'
//
// Ports
//   i_clk            clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_bus_data       write data, right-aligned (byte [7:0], half [15:0])
//   i_bus_address    byte address
//   i_bus_DV         request valid
//   i_bhw            access size, one-hot: 001 byte, 010 half, 100 word
//   i_write_notread  1 = write, 0 = read
//   o_bus_data       read data, zero-extended and right-aligned; 0 for writes
//   o_bus_DV         one-cycle response pulse
//   o_bus_err        one-cycle error pulse (BUS_MEM_MISALIGN_ERR_EN only)
//   o_dbg_state      current request FSM state (0 idle, 1 wait, 2 resp)
//
// Handshake: a request is taken when i_bus_DV is high at a rising edge while
// the FSM is idle. There is no ready signal. i_bus_DV is ignored in every
// other state. The response is a single-cycle o_bus_DV pulse in the cycle
// after edge N+LATENCY, where N is the edge that took the request.
//
// Build option
//   BUS_MEM_MISALIGN_ERR_EN  when defined, a misaligned half/word access or a
//   non-one-hot i_bhw completes with o_bus_err. It does not write RAM and
//   returns 0. When undefined, the low address bits are forced to alignment,
//   invalid sizes are treated as word accesses, and o_bus_err is tied 0.
// -----------------------------------------------------------------------------
module bus_memory #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 2,
  parameter     INIT_FILE   = ""
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_bus_data,
  input  logic [ADDR_W-1:0] i_bus_address,
  input  logic              i_bus_DV,
  input  logic [2:0]        i_bhw,
  input  logic              i_write_notread,
  output logic [DATA_W-1:0] o_bus_data,
  output logic              o_bus_DV,
  output logic              o_bus_err,
  output logic [1:0]        o_dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  wait_cnt;

  // Captured request
  logic [AW-1:0] q_idx;
  logic [1:0]    q_off;
  logic [3:0]    q_be;
  logic [31:0]   q_wdata;
  logic          q_wr;
  logic          q_byte;
  logic          q_half;
  logic          q_bad;

  logic [31:0] mem [DEPTH_WORDS];

  // Upper address bits are deliberately ignored, so addresses wrap.
  logic unused_addr;
  assign unused_addr = ^i_bus_address[ADDR_W-1:AW+2];

  // ---------------------------------------------------------------------------
  // Request decode. Invalid sizes fall through to word. Alignment is forced
  // by taking the lane offset from the address bits that the size permits.
  // ---------------------------------------------------------------------------
  logic        req_byte, req_half, req_bad;
  logic [1:0]  req_off;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;

  always_comb begin
    req_byte = (i_bhw == 3'b001);
    req_half = (i_bhw == 3'b010);
    req_bad  = 1'b0;
`ifdef BUS_MEM_MISALIGN_ERR_EN
    req_bad  = (req_half && i_bus_address[0]) ||
               (!req_byte && !req_half &&
                ((i_bhw != 3'b100) || (i_bus_address[1:0] != 2'b00)));
`endif
    if (req_byte) begin
      req_off   = i_bus_address[1:0];
      req_be    = 4'b0001 << i_bus_address[1:0];
      req_wdata = {4{i_bus_data[7:0]}};
    end else if (req_half) begin
      req_off   = {i_bus_address[1], 1'b0};
      req_be    = i_bus_address[1] ? 4'b1100 : 4'b0011;
      req_wdata = {2{i_bus_data[15:0]}};
    end else begin
      req_off   = 2'b00;
      req_be    = 4'b1111;
      req_wdata = i_bus_data[31:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: select the addressed lanes of the captured word and
  // right-align them.
  // ---------------------------------------------------------------------------
  logic [31:0] rd_word, rd_shift, rd_lane;

  always_comb begin
    rd_word  = mem[q_idx];
    rd_shift = rd_word >> {q_off, 3'b000};
    if (q_byte)      rd_lane = {24'h0, rd_shift[7:0]};
    else if (q_half) rd_lane = {16'h0, rd_shift[15:0]};
    else             rd_lane = rd_shift;
  end

  // ---------------------------------------------------------------------------
  // Request FSM. The commit edge is the edge that leaves RESP. RAM is written
  // and read data is latched on that same edge that raises o_bus_DV.
  // ---------------------------------------------------------------------------
  logic resp_err_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      wait_cnt   <= 8'd0;
      o_bus_DV   <= 1'b0;
      o_bus_data <= '0;
      resp_err_d <= 1'b0;
      q_idx      <= '0;
      q_off      <= 2'b00;
      q_be       <= 4'b0000;
      q_wdata    <= 32'h0;
      q_wr       <= 1'b0;
      q_byte     <= 1'b0;
      q_half     <= 1'b0;
      q_bad      <= 1'b0;
    end else begin
      o_bus_DV   <= 1'b0;
      resp_err_d <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_bus_DV) begin
            q_idx   <= i_bus_address[AW+1:2];
            q_off   <= req_off;
            q_be    <= req_be;
            q_wdata <= req_wdata;
            q_wr    <= i_write_notread;
            q_byte  <= req_byte;
            q_half  <= req_half;
            q_bad   <= req_bad;
            if (LATENCY > 1) begin
              state    <= ST_WAIT;
              // WAIT lasts LATENCY-1 cycles and exits when the count reaches 0.
              wait_cnt <= 8'(LATENCY - 2);
            end else begin
              state <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 8'd0) state <= ST_RESP;
          else                  wait_cnt <= wait_cnt - 8'd1;
        end
        ST_RESP: begin
          o_bus_DV   <= 1'b1;
          resp_err_d <= q_bad;
          o_bus_data <= (q_wr || q_bad) ? '0 : rd_lane;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef BUS_MEM_MISALIGN_ERR_EN
  assign o_bus_err = resp_err_d;
`else
  logic unused_err;
  assign unused_err = resp_err_d;
  assign o_bus_err  = 1'b0;
`endif

  assign o_dbg_state = state;

  // ---------------------------------------------------------------------------
  // RAM write port with byte enables. An asynchronous reset forces the FSM
  // out of RESP, so an aborted transaction can never reach this port.
  // ---------------------------------------------------------------------------
  logic ram_we;
  assign ram_we = (state == ST_RESP) && q_wr && !q_bad;

  always_ff @(posedge i_clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (q_be[i]) mem[q_idx][8*i +: 8] <= q_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_bus_memory.sv
// -----------------------------------------------------------------------------
// tb_bus_memory
//   Self-checking bench for bus_memory (LATENCY=3, DEPTH_WORDS=16).
//   The bench applies a table of directed vectors first. Hand-written
//   sequences then cover a held request, re-pulsed requests and a reset in
//   the middle of a transaction. Randomized accesses follow, checked against
//   a byte-array reference model.
// -----------------------------------------------------------------------------
module tb_bus_memory;

  localparam int LAT   = 3;
  localparam int DEPTH = 16;
`ifdef BUS_MEM_MISALIGN_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] bus_data = 32'h0;
  logic [31:0] bus_address = 32'h0;
  logic        bus_dv = 1'b0;
  logic [2:0]  bhw = 3'b100;
  logic        write_notread = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_dv;
  logic        rsp_err;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  bus_memory #(
    .DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT), .INIT_FILE("")
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_bus_data(bus_data), .i_bus_address(bus_address), .i_bus_DV(bus_dv),
    .i_bhw(bhw), .i_write_notread(write_notread),
    .o_bus_data(rsp_data), .o_bus_DV(rsp_dv), .o_bus_err(rsp_err),
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Byte-addressed memory. An access covers n = 1, 2 or 4 bytes starting at
  // the address rounded down to a multiple of n, modulo the memory size.
  logic [7:0] model_mem [DEPTH*4];

  function automatic void model_access(input logic [31:0] a, input logic [31:0] d,
                                       input logic [2:0] size, input logic wr,
                                       output logic [31:0] rd, output logic err);
    int n, base;
    bit one_hot;
    one_hot = (size == 3'b001) || (size == 3'b010) || (size == 3'b100);
    n    = (size == 3'b001) ? 1 : (size == 3'b010) ? 2 : 4;
    rd   = 32'h0;
    err  = 1'b0;
    if (ERR_EN && (!one_hot || (int'(a % 32'(n)) != 0))) begin
      err = 1'b1;
      return;
    end
    base = int'(a % 32'(DEPTH*4));
    base = base - (base % n);
    for (int i = 0; i < n; i++) begin
      if (wr) model_mem[base+i] = d[8*i +: 8];
      else    rd[8*i +: 8]      = model_mem[base+i];
    end
  endfunction

  // ---------------- driver ----------------
  // Issue one request. The request is sampled at the next rising edge (N).
  // Then watch edges N+1 .. N+LAT+3 and record when and how often DV fires.
  task automatic do_req(input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] size, input logic wr,
                        output int first_k, output int n_dv,
                        output logic [31:0] rdata, output logic err);
    first_k = -1;
    n_dv    = 0;
    rdata   = 32'hx;
    err     = 1'bx;
    @(negedge clk);
    bus_address = a; bus_data = d; bhw = size; write_notread = wr; bus_dv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_dv = 1'b0;
    for (int k = 1; k <= LAT + 3; k++) begin
      @(posedge clk); #1;
      if (rsp_dv === 1'b1) begin
        n_dv++;
        if (first_k < 0) begin
          first_k = k;
          rdata   = rsp_data;
          err     = rsp_err;
        end
      end
    end
  endtask

  task automatic run_access(input string name, input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] size, input logic wr,
                            input logic [31:0] exp_d, input logic exp_e);
    int fk, nd;
    logic [31:0] rdata;
    logic err;
    exp_q.push_back(exp_d);
    do_req(a, d, size, wr, fk, nd, rdata, err);
    check({name, ".latency"}, 32'(fk), 32'(LAT));
    check({name, ".dv_count"}, 32'(nd), 32'd1);
    check({name, ".data"}, rdata, exp_q.pop_front());
    check({name, ".err"}, {31'h0, err}, {31'h0, exp_e});
  endtask

  // Drive i_bus_DV with a per-edge pattern (bit k applies to edge N+k) and
  // record the response edges.
  task automatic dv_pattern(input logic [31:0] a, input logic [15:0] pat,
                            output int n_dv, output int k0, output int k1,
                            output logic [31:0] d0, output logic [31:0] d1);
    n_dv = 0; k0 = -1; k1 = -1; d0 = 32'hx; d1 = 32'hx;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      bus_address = a; bhw = 3'b100; write_notread = 1'b0; bus_dv = pat[k];
      @(posedge clk); #1;
      if (rsp_dv === 1'b1) begin
        n_dv++;
        if (k0 < 0) begin k0 = k; d0 = rsp_data; end
        else if (k1 < 0) begin k1 = k; d1 = rsp_data; end
      end
    end
    @(negedge clk);
    bus_dv = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  size;
    logic        wr;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s,
                              input logic wr, input logic [31:0] ed, input logic ee);
    vec_t v;
    v.addr = a; v.data = d; v.size = s; v.wr = wr; v.exp_data = ed; v.exp_err = ee;
    return v;
  endfunction

  localparam logic [2:0] B = 3'b001, H = 3'b010, W = 3'b100;

  initial begin
    logic [31:0] ed;
    logic        ee;
    int          nd, k0, k1, fk;
    logic [31:0] d0, d1, rd;
    logic        re;
    logic [31:0] a, d;
    logic [2:0]  s;
    logic        wr;

    vecs.push_back(mk(32'h10, 32'hDEADBEEF, W, 1, 32'h0, 0));
    vecs.push_back(mk(32'h10, 32'h0,        W, 0, 32'hDEADBEEF, 0));
    vecs.push_back(mk(32'h10, 32'h11223344, W, 1, 32'h0, 0));
    vecs.push_back(mk(32'h13, 32'hAA,       B, 1, 32'h0, 0));
    vecs.push_back(mk(32'h10, 32'h0,        W, 0, 32'hAA223344, 0));
    vecs.push_back(mk(32'h13, 32'h0,        B, 0, 32'h000000AA, 0));
    vecs.push_back(mk(32'h12, 32'h0,        H, 0, 32'h0000AA22, 0));
    vecs.push_back(mk(32'h00, 32'h0,        W, 1, 32'h0, 0));
    vecs.push_back(mk(32'h40, 32'h55,       B, 1, 32'h0, 0));
    vecs.push_back(mk(32'h00, 32'h0,        W, 0, 32'h00000055, 0));
    vecs.push_back(mk(32'h00, 32'h0,        B, 0, 32'h00000055, 0));
    vecs.push_back(mk(32'h20, 32'h0,        W, 1, 32'h0, 0));
    vecs.push_back(mk(32'h21, 32'h12345678, W, 1, 32'h0, ERR_EN));
    vecs.push_back(mk(32'h20, 32'h0,        W, 0, ERR_EN ? 32'h0 : 32'h12345678, 0));
    vecs.push_back(mk(32'h14, 32'h0,        W, 1, 32'h0, 0));
    vecs.push_back(mk(32'h17, 32'hBEEF,     H, 1, 32'h0, ERR_EN));
    vecs.push_back(mk(32'h14, 32'h0,        W, 0, ERR_EN ? 32'h0 : 32'hBEEF0000, 0));
    vecs.push_back(mk(32'h15, 32'h0,        H, 0, 32'h0, ERR_EN));
    vecs.push_back(mk(32'h18, 32'h0,        W, 1, 32'h0, 0));
    vecs.push_back(mk(32'h18, 32'hCAFEF00D, 3'b011, 1, 32'h0, ERR_EN));
    vecs.push_back(mk(32'h18, 32'h0,        W, 0, ERR_EN ? 32'h0 : 32'hCAFEF00D, 0));
    vecs.push_back(mk(32'h1A, 32'h0,        H, 0, ERR_EN ? 32'h0 : 32'h0000CAFE, 0));
    vecs.push_back(mk(32'h19, 32'h0,        B, 0, ERR_EN ? 32'h0 : 32'h000000F0, 0));

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    check("reset.dv",    {31'h0, rsp_dv},  32'h0);
    check("reset.data",  rsp_data,         32'h0);
    check("reset.err",   {31'h0, rsp_err}, 32'h0);
    check("reset.state", {30'h0, dbg_state}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- directed table ----
    foreach (vecs[i]) begin
      model_access(vecs[i].addr, vecs[i].data, vecs[i].size, vecs[i].wr, ed, ee);
      run_access($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].size,
                 vecs[i].wr, vecs[i].exp_data, vecs[i].exp_err);
    end

    // ---- held request: one response every LAT+1 cycles ----
    model_access(32'h10, 32'h0, W, 1'b0, ed, ee);
    dv_pattern(32'h10, 16'h00FF, nd, k0, k1, d0, d1);
    check("held.count", 32'(nd), 32'd2);
    check("held.first", 32'(k0), 32'(LAT));
    check("held.second", 32'(k1), 32'(2*LAT + 1));
    check("held.data0", d0, ed);
    check("held.data1", d1, ed);

    // ---- re-pulses during WAIT/RESP are ignored ----
    dv_pattern(32'h10, 16'b0000_0000_0000_1101, nd, k0, k1, d0, d1);
    check("repulse.count", 32'(nd), 32'd1);
    check("repulse.first", 32'(k0), 32'(LAT));

    // ---- reset in the middle of a write ----
    model_access(32'h30, 32'h0BADF00D, W, 1'b1, ed, ee);
    run_access("pre_rst_wr", 32'h30, 32'h0BADF00D, W, 1'b1, 32'h0, 1'b0);
    model_access(32'h30, 32'h0, W, 1'b0, ed, ee);
    run_access("pre_rst_rd", 32'h30, 32'h0, W, 1'b0, ed, 1'b0);
    @(negedge clk);
    bus_address = 32'h30; bus_data = 32'hFFFFFFFF; bhw = W; write_notread = 1'b1; bus_dv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_dv = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst.data", rsp_data, 32'h0);
    check("midrst.state", {30'h0, dbg_state}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < LAT + 3; k++) begin
      @(posedge clk); #1;
      if (rsp_dv === 1'b1) nd++;
    end
    check("midrst.no_dv", 32'(nd), 32'd0);
    run_access("post_rst_rd", 32'h30, 32'h0, W, 1'b0, ed, 1'b0);

    // ---- randomized accesses against the model ----
    for (int w = 0; w < DEPTH; w++) begin
      d = $urandom;
      model_access(32'(w*4), d, W, 1'b1, ed, ee);
      run_access($sformatf("fill%0d", w), 32'(w*4), d, W, 1'b1, ed, ee);
    end
    for (int i = 0; i < 60; i++) begin
      a  = 32'($urandom_range(0, DEPTH*8 - 1));
      d  = $urandom;
      wr = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0, 1, 2: s = B;
        3, 4, 5: s = H;
        6, 7, 8: s = W;
        default: s = 3'($urandom_range(0, 7));
      endcase
      model_access(a, d, s, wr, ed, ee);
      run_access($sformatf("rnd%0d", i), a, d, s, wr, ed, ee);
    end

    // The whole memory is read back through the bus to finish.
    for (int w = 0; w < DEPTH; w++) begin
      model_access(32'(w*4), 32'h0, W, 1'b0, ed, ee);
      do_req(32'(w*4), 32'h0, W, 1'b0, fk, nd, rd, re);
      check($sformatf("dump%0d", w), rd, ed);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
